// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, character width, buffer depth and TX FSM states.
// StParity exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned UART_DBIT   = 8;
    localparam int unsigned TXBUF_DEPTH = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop,
        StPop,
        StDone
    } tx_state_t;

endpackage

// File: rtl/uart_tx_shifter.sv
// Character serializer: shift register, tick/bit counters and the registered tx line.
// UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = UART_DBIT,
    parameter int unsigned SB_TICK = OVERSAMPLE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            load,
    input  logic            in_start,
    input  logic            in_data,
`ifdef UART_TX_PARITY_EN
    input  logic            in_parity,
`endif
    input  logic            in_stop,
    input  logic [DBIT-1:0] din,
    output logic            seg_done,
    output logic            byte_done,
    output logic            tx
);

    localparam int unsigned TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int unsigned BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [TW-1:0] BitTickLast  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] StopTickLast = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BitCntLast   = BW'(DBIT - 1);

    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            counting, tick_end;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
    assign counting = in_start | in_data | in_parity | in_stop;
`else
    assign counting = in_start | in_data | in_stop;
`endif

    // Ticks outside the character segments (LOAD/POP/DONE/IDLE) never advance the counter.
    assign tick_end  = s_tick & counting &
                       (in_stop ? (tick_q == StopTickLast) : (tick_q == BitTickLast));
    assign seg_done  = tick_end & (~in_data | (bit_q == BitCntLast));
    assign byte_done = tick_end & in_stop;
    assign tx        = tx_q;

    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (load) begin
            shreg_d = din;
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^din;
`endif
        end else if (s_tick && counting) begin
            tick_d = tick_end ? '0 : tick_q + 1'b1;
            if (tick_end) begin
                if (in_start) begin
                    tx_d = shreg_q[0];
                end else if (in_data) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                    tx_d    = seg_done ? par_q : shreg_d[0];
`else
                    tx_d    = seg_done ? 1'b1 : shreg_d[0];
`endif
                end else begin
                    tx_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame controller: drains FRAME_BYTES bytes from the TX buffer once it is full.
// Define UART_TX_PARITY_EN for 8E1 characters; default is 8N1.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DBIT        = UART_DBIT,
    parameter int unsigned SB_TICK     = OVERSAMPLE,
    parameter int unsigned FRAME_BYTES = TXBUF_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            buf_full,
    input  logic [DBIT-1:0] buf_data,
    output logic            buf_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int unsigned CW = $clog2(FRAME_BYTES) + 1;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] byte_q, byte_d;
    logic          seg_done, byte_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        unique case (state_q)
            StIdle:  if (buf_full) state_d = StLoad;
            StLoad:  state_d = StStart;
            StStart: if (seg_done) state_d = StData;
`ifdef UART_TX_PARITY_EN
            StData:   if (seg_done) state_d = StParity;
            StParity: if (seg_done) state_d = StStop;
`else
            StData:  if (seg_done) state_d = StStop;
`endif
            StStop:  if (byte_done) state_d = StPop;
            StPop: begin
                byte_d  = byte_q + 1'b1;
                state_d = (byte_d == CW'(FRAME_BYTES)) ? StDone : StLoad;
            end
            // One cycle here lets buf_full fall before IDLE samples it again.
            StDone: begin
                byte_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        buf_rd       = (state_q == StPop);
        tx_busy      = (state_q != StIdle);
        tx_done_tick = (state_q == StDone);
    end

    uart_tx_shifter #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .s_tick    (s_tick),
        .load      (state_q == StLoad),
        .in_start  (state_q == StStart),
        .in_data   (state_q == StData),
`ifdef UART_TX_PARITY_EN
        .in_parity (state_q == StParity),
`endif
        .in_stop   (state_q == StStop),
        .din       (buf_data),
        .seg_done  (seg_done),
        .byte_done (byte_done),
        .tx        (tx)
    );

endmodule
